// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
//   Transmit side of the host serial link. Buffers `WORD_WIDTH-bit (16-bit)
//   result words in a small FIFO and sends each one as two UART bytes on tx.
//   The high byte goes first, then the low byte. Each byte is sent LSB first.
//   Words waiting in the FIFO are sent back to back, with no idle bit between
//   them.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : 8E1 frames (start, 8 data, even parity, stop) = 11 bits
//   undefined : 8N1 frames (start, 8 data, stop)              = 10 bits
//   The host receiver must be configured the same way.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per line bit; must be >= 2
//   FIFO_DEPTH   : input FIFO entries; must be a power of 2 and >= 2
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low; aborts any frame in flight
//   word_in    in   word to transmit
//   word_valid in   word_in is valid; the producer holds it until accepted
//   word_ready out  FIFO can accept a word (registered, 0 when full)
//   tx         out  serial line, idle high, registered
//   busy       out  a frame is in progress or the FIFO holds a word
//   words_sent out  count of fully transmitted words, wraps at 0xFFFF
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module uart_word_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`WORD_WIDTH-1:0] word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [15:0]            words_sent
);

    localparam int W     = `WORD_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic [W-1:0]     head;
    logic             push;
    logic             pop;

    assign push = word_valid && word_ready;
    assign head = mem[rd_ptr];

    // NOTE: the storage array has no reset; the count and pointers decide
    // what is valid, so resetting the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word_in;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples values from before the edge. The combinational blocks use
    // blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            word_ready <= 1'b1;
        end else begin
            // Power-of-2 depth lets the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_d;
            // Registered copy of "not full". A pop in the same cycle as a
            // full FIFO does not let a word in until the next cycle.
            word_ready <= (count_d != FULL);
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             hi_q, hi_d;          // 1: sending the high byte
    logic [W-1:0]     word_q, word_d;
    logic [15:0]      sent_q, sent_d;
    logic             line;
    logic             bit_end;
    logic [7:0]       cur_byte;

    assign bit_end  = (tmr_q == TMR_MAX);
    assign cur_byte = hi_q ? word_q[W-1:W/2] : word_q[W/2-1:0];

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        hi_d      = hi_q;
        word_d    = word_q;
        sent_d    = sent_q;
        pop       = 1'b0;
        line      = 1'b1;
        // The bit timer reloads on every bit boundary, and it is held at zero
        // while idle, so every frame starts on a fresh bit period.
        tmr_d     = (state_q == S_IDLE || bit_end) ? '0 : tmr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    word_d  = head;
                    hi_d    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                line = 1'b0;
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                line = cur_byte[bit_idx_q];
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                line = ^cur_byte;
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (hi_q) begin
                        hi_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        sent_d = sent_q + 16'd1;
                        // Chain straight into the next word if one is waiting.
                        if (count != '0) begin
                            pop     = 1'b1;
                            word_d  = head;
                            hi_d    = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            bit_idx_q <= 3'd0;
            hi_q      <= 1'b1;
            word_q    <= '0;
            sent_q    <= 16'd0;
            tx        <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_idx_q <= bit_idx_d;
            hi_q      <= hi_d;
            word_q    <= word_d;
            sent_q    <= sent_d;
            tx        <= line;
        end
    end

    assign busy       = (state_q != S_IDLE) || (count != '0);
    assign words_sent = sent_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx. Accepted words queue their expected bytes on a
// scoreboard. An independent UART receiver samples tx at mid-bit and checks
// each frame against that scoreboard.
module tb_uart_word_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int PER   = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_T = FB * CPB * PER;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] word_in = 16'h0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;

    uart_word_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tx         (tx),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #(PER/2) clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        logic [7:0] data;
        bit         lo;    // low byte: always follows its high byte with no gap
        bit         b2b;   // high byte queued behind a previous word: no gap
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_sent = 16'h0;
    bit          saw_not_ready = 1'b0;
    time         accept_t;

    // ------------------------------------------------------ receiver monitor
    bit         rx_on = 1'b0;
    int         rx_cnt;
    int         rx_bit;
    logic [7:0] rx_byte;
    logic       rx_par;
    time        start_t;
    time        last_start_t;
    bit         last_valid = 1'b0;
    int         starts = 0;
    exp_t       e;

    always @(negedge clk) begin
        if (!rst) begin
            rx_on      = 1'b0;
            last_valid = 1'b0;
            exp_q.delete();
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on   = 1'b1;
                rx_cnt  = 0;
                start_t = $time;
                starts++;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_bit = rx_cnt / CPB;
                if (rx_bit == 0) begin
                    check("start_bit", 32'(tx), 32'd0);
                end else if (rx_bit <= 8) begin
                    rx_byte[rx_bit-1] = tx;
                end else if (rx_bit < FB - 1) begin
                    rx_par = tx;
                end else begin
                    check("stop_bit", 32'(tx), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", rx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(rx_byte), 32'(e.data));
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", 32'(rx_par), 32'(^e.data));
`endif
                        if ((e.lo || e.b2b) && last_valid)
                            check("start_to_start", 32'(start_t - last_start_t), 32'(FRAME_T));
                    end
                    last_start_t = start_t;
                    last_valid   = 1'b1;
                    rx_on        = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic send_word(input logic [15:0] w, input bit b2b);
        bit acc;
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            word_in    = w;
            word_valid = 1'b1;
            acc        = word_ready;
            if (!acc) saw_not_ready = 1'b1;
            @(posedge clk);
            if (acc) begin
                ok       = 1'b1;
                accept_t = $time;
                exp_sent = exp_sent + 16'd1;
                exp_q.push_back(exp_t'{data: w[15:8], lo: 1'b0, b2b: b2b});
                exp_q.push_back(exp_t'{data: w[7:0],  lo: 1'b1, b2b: 1'b0});
            end
        end
        #1 word_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_start(input int s0);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (starts != s0) seen = 1'b1;
        end
        if (!seen) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (busy === 1'b0 && !rx_on && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic idle_high(input int cycles, input string name);
        int bad = 0;
        int s0  = starts;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check(name, 32'(bad), 32'd0);
        check({name, "_no_frame"}, 32'(starts - s0), 32'd0);
    endtask

    initial begin
        #(PER * 90000);
        $display("FAIL watchdog: simulation did not finish, expected finish before t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- sequence
    initial begin
        time         t0;
        time         target;
        int          s0;
        logic [15:0] w;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_tx",         32'(tx),         32'd1);
        check("rst_word_ready", 32'(word_ready), 32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_words_sent", 32'(words_sent), 32'd0);
        rst = 1'b1;
        idle_high(100, "idle_tx_low_cycles");

        // One word: latency, busy, and the exact cycle words_sent moves.
        s0 = starts;
        send_word(16'hA55A, 1'b0);
        wait_start(s0);
        t0 = start_t;
        check("start_latency", 32'(start_t - accept_t), 32'(2 * PER + PER / 2));
        check("busy_in_frame", 32'(busy), 32'd1);
        target = t0 + (2 * FB * CPB - 3) * PER + 2;
        #(target - $time);
        check("words_sent_before_end", 32'(words_sent), 32'd0);
        target = t0 + (2 * FB * CPB - 1) * PER + 2;
        #(target - $time);
        check("words_sent_after_word", 32'(words_sent), 32'(exp_sent));
        wait_idle();
        check("busy_after_word", 32'(busy), 32'd0);

        // Six words with valid held: FIFO fills, line stays gap-free.
        saw_not_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            w = 16'($urandom);
            send_word(w, k != 0);
        end
        check("ready_dropped_when_full", 32'(saw_not_ready), 32'd1);
        wait_idle();
        check("words_sent_burst", 32'(words_sent), 32'(exp_sent));
        check("ready_after_burst", 32'(word_ready), 32'd1);

        // Random words with random idle gaps.
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            w = 16'($urandom);
            send_word(w, 1'b0);
        end
        wait_idle();
        check("words_sent_random", 32'(words_sent), 32'(exp_sent));

        // Reset during data bit 3 of the low byte, with a second word queued.
        s0 = starts;
        send_word(16'h1234, 1'b0);
        wait_start(s0);
        t0 = start_t;
        send_word(16'hBEEF, 1'b0);
        target = t0 + (FB * CPB + 4 * CPB + 1) * PER + 2;
        #(target - $time);
        check("tx_low_before_reset", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_tx_high",      32'(tx),         32'd1);
        check("reset_busy",         32'(busy),       32'd0);
        check("reset_word_ready",   32'(word_ready), 32'd1);
        check("reset_words_sent",   32'(words_sent), 32'd0);
        exp_sent = 16'h0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        idle_high(30, "post_reset_tx_low_cycles");
        send_word(16'h00FF, 1'b0);
        wait_idle();
        check("words_sent_after_reset", 32'(words_sent), 32'(exp_sent));

        // Counter wrap from a preloaded 0xFFFF.
        @(negedge clk);
        force dut.sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.sent_q;
        exp_sent = 16'hFFFF;
        check("words_sent_preload", 32'(words_sent), 32'(exp_sent));
        send_word(16'h3C96, 1'b0);
        wait_idle();
        check("words_sent_wrap", 32'(words_sent), 32'(exp_sent));

`ifdef UART_TX_PARITY_EN
        // Both bytes have odd weight, so both parity bits are 1.
        send_word(16'h0701, 1'b0);
        wait_idle();
        check("words_sent_parity", 32'(words_sent), 32'(exp_sent));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
